// File: rtl/exp_mu_table_reader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exp_mu_table_reader_if : table-read port and S0*exp(t*mu) output stream.
// Rev 1.0
// ----------------------------------------------------------------------------
interface exp_mu_table_reader_if #(
  parameter int logT = 9
);
  logic            iTableDone;
  logic            oRdEn;
  logic [logT-1:0] oRdAddr;
  logic [17:0]     iRdData;
  logic [17:0]     oData;
  logic [logT-1:0] oT;
  logic            oValid;
  logic            iReady;
  logic            oLast;
  logic            oBusy;

  modport slave (
    input  iTableDone, iRdData, iReady,
    output oRdEn, oRdAddr, oData, oT, oValid, oLast, oBusy
  );

  modport master (
    output iTableDone, iRdData, iReady,
    input  oRdEn, oRdAddr, oData, oT, oValid, oLast, oBusy
  );
endinterface
`default_nettype wire

// File: rtl/exp_mu_table_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exp_mu_table_reader : sweeps table t_min..t_max into a ready/valid stream.
// Option EXPMU_RD_PENDING_EN re-arms a sweep requested while busy. Rev 1.0
// ----------------------------------------------------------------------------
module exp_mu_table_reader #(
  parameter int t_min = 171,
  parameter int t_max = 341,
  parameter int logT  = 9
) (
  input  wire logic             CLK,
  input  wire logic             iRST_n,
  exp_mu_table_reader_if.slave  bus
);
  localparam logic [logT-1:0] c_T_MIN = logT'(t_min);
  localparam logic [logT-1:0] c_T_MAX = logT'(t_max);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [logT-1:0] addr_q, addr_d;
  logic            infl_q;
  logic [logT-1:0] infl_t_q;
  logic [17:0]     data_q [2];
  logic [logT-1:0] t_q    [2];
  logic            wptr_q, rptr_q;
  logic [1:0]      cnt_q;

  logic            pop;
  logic            rd_en;
  logic            last_xfer;
  logic [1:0]      occ;
`ifdef EXPMU_RD_PENDING_EN
  logic            pending_q, pending_d;
`endif

  // Occupancy counts the word leaving this cycle as gone, so a full-rate
  // stream keeps one read in flight and one word buffered.
  assign pop       = (cnt_q != 2'd0) && bus.iReady;
  assign occ       = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign rd_en     = (state_q == READ) && (occ < 2'd2);
  assign last_xfer = pop && (t_q[rptr_q] == c_T_MAX);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef EXPMU_RD_PENDING_EN
    pending_d = pending_q;
    if ((state_q != IDLE) && bus.iTableDone) begin
      pending_d = 1'b1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (bus.iTableDone) begin
          state_d = READ;
          addr_d  = c_T_MIN;
        end
      end
      READ: begin
        if (rd_en) begin
          if (addr_q == c_T_MAX) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + logT'(1);
          end
        end
      end
      DRAIN: begin
        if (last_xfer) begin
`ifdef EXPMU_RD_PENDING_EN
          if (pending_q || bus.iTableDone) begin
            state_d   = READ;
            addr_d    = c_T_MIN;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      infl_q    <= 1'b0;
      infl_t_q  <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      t_q[0]    <= '0;
      t_q[1]    <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      infl_q  <= rd_en;
      if (rd_en) begin
        infl_t_q <= addr_q;
      end
      if (infl_q) begin
        data_q[wptr_q] <= bus.iRdData;
        t_q[wptr_q]    <= infl_t_q;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

`ifdef EXPMU_RD_PENDING_EN
  always_ff @(posedge CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`endif

  assign bus.oRdEn   = rd_en;
  assign bus.oRdAddr = addr_q;
  assign bus.oValid  = (cnt_q != 2'd0);
  assign bus.oData   = data_q[rptr_q];
  assign bus.oT      = t_q[rptr_q];
  assign bus.oLast   = (cnt_q != 2'd0) && (t_q[rptr_q] == c_T_MAX);
  assign bus.oBusy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exp_mu_table_reader.sv
`default_nettype none
// Bench for exp_mu_table_reader: queue-based reference of the t_min..t_max
// sweep, registered table model, directed steps with randomized iReady/data.
module tb_exp_mu_table_reader;
  localparam int TMIN = 171;
  localparam int TMAX = 341;
  localparam int LOGT = 9;
`ifdef EXPMU_RD_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  exp_mu_table_reader_if #(.logT(LOGT)) bus  ();
  exp_mu_table_reader_if #(.logT(LOGT)) bus5 ();

  exp_mu_table_reader #(.t_min(TMIN), .t_max(TMAX), .logT(LOGT)) dut (
    .CLK(CLK), .iRST_n(rst_n), .bus(bus));
  exp_mu_table_reader #(.t_min(5), .t_max(5), .logT(LOGT)) dut5 (
    .CLK(CLK), .iRST_n(rst_n), .bus(bus5));

  logic [17:0] mem [0:511];
  always @(posedge CLK) if (bus.oRdEn)  bus.iRdData  <= mem[bus.oRdAddr];
  always @(posedge CLK) if (bus5.oRdEn) bus5.iRdData <= mem[bus5.oRdAddr];

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          rd_next = TMIN;
  int          issued = 0;
  int          xfer = 0;
  bit          prev_stall = 1'b0;
  logic [17:0] prev_d = '0;
  logic [8:0]  prev_t = '0;
  bit          saw_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    rd_next = TMIN; issued = 0; xfer = 0; prev_stall = 1'b0; saw_last = 1'b0;
  endtask

  task automatic push_sweep();
    for (int t = TMIN; t <= TMAX; t++) exp_q.push_back(t);
  endtask

  task automatic sample();
    int e;
    chk("occupancy_le2", 32'(issued - xfer <= 2), 1);
    if (bus.oRdEn) begin
      chk("rd_addr", bus.oRdAddr, rd_next);
      rd_next = (rd_next == TMAX) ? TMIN : rd_next + 1;
      issued++;
    end
    if (prev_stall) begin
      chk("stall_valid", bus.oValid, 1);
      chk("stall_data", bus.oData, prev_d);
      chk("stall_t", bus.oT, prev_t);
    end
    saw_last = 1'b0;
    if (bus.oValid && bus.iReady) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", {31'b0, bus.oValid}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_t", bus.oT, e);
        chk("word_data", bus.oData, mem[e]);
        chk("word_last", bus.oLast, (e == TMAX));
        chk("busy_during_xfer", bus.oBusy, 1);
        saw_last = (e == TMAX);
      end
      xfer++;
    end
    prev_stall = bus.oValid && !bus.iReady;
    prev_d     = bus.oData;
    prev_t     = bus.oT;
  endtask

  task automatic cycle(input bit rdy, input bit done);
    @(posedge CLK); #1;
    bus.iReady     = rdy;
    bus.iTableDone = done;
    @(negedge CLK);
    sample();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rden"},  bus.oRdEn, 0);
    chk({tag, "_addr"},  bus.oRdAddr, 0);
    chk({tag, "_data"},  bus.oData, 0);
    chk({tag, "_t"},     bus.oT, 0);
    chk({tag, "_valid"}, bus.oValid, 0);
    chk({tag, "_last"},  bus.oLast, 0);
    chk({tag, "_busy"},  bus.oBusy, 0);
  endtask

  task automatic run_until_idle(input int mode, input int budget, input string tag);
    int n = 0;
    bit r;
    while ((exp_q.size() != 0 || bus.oBusy) && n < budget) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((n % 4) == 0) || ((n % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      cycle(r, 1'b0);
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_idle"}, bus.oBusy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int n5_rd;
    int n5_val;

    bus.iReady = 1'b0;  bus.iTableDone = 1'b0;
    bus5.iReady = 1'b1; bus5.iTableDone = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 18'(i);

    // Reset state, with iTableDone pulsed while held in reset
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1 bus.iTableDone = 1'b1;
    @(posedge CLK); #1 bus.iTableDone = 1'b0;
    @(negedge CLK); #1 rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    chk("done_in_reset_ignored", bus.oBusy, 0);

    // Full-rate sweep: latency 3, contiguous words, busy drops after t_max
    push_sweep();
    cycle(1'b1, 1'b1);
    chk("busy_on_pulse_cycle", bus.oBusy, 0);
    for (lat = 1; lat <= 10; lat++) begin
      cycle(1'b1, 1'b0);
      if (lat == 1) chk("busy_rise", bus.oBusy, 1);
      if (bus.oValid) break;
    end
    chk("first_valid_latency", lat, 3);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cycle(1'b1, 1'b0);
      chk("contiguous_valid", bus.oValid, 1);
      n++;
    end
    chk("sweep1_drained", exp_q.size(), 0);
    cycle(1'b1, 1'b0);
    chk("busy_fall", bus.oBusy, 0);
    chk("valid_after_sweep", bus.oValid, 0);

    // iReady 1,0,0,1 stall pattern
    push_sweep();
    cycle(1'b1, 1'b1);
    run_until_idle(1, 2000, "pattern");

    // Random table contents and random iReady
    for (int i = 0; i < 512; i++) mem[i] = 18'($urandom);
    push_sweep();
    cycle(1'b1, 1'b1);
    run_until_idle(2, 2000, "random");

    // Asynchronous reset while word t=200 is presented
    push_sweep();
    cycle(1'b1, 1'b1);
    n = 0;
    do begin
      cycle(1'b1, 1'b0);
      n++;
    end while (!(bus.oValid && bus.oT == 9'd200) && n < 400);
    chk("reached_200", bus.oT, 200);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    clear_model();
    bus.iTableDone = 1'b1;
    @(posedge CLK); #1 bus.iTableDone = 1'b0;
    @(negedge CLK); #1 rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    chk("no_sweep_after_reset", bus.oBusy, 0);
    push_sweep();
    cycle(1'b1, 1'b1);
    run_until_idle(2, 2000, "restart");

    // Second iTableDone while busy, at word t=250
    push_sweep();
    cycle(1'b1, 1'b1);
    n = 0;
    do begin
      cycle(1'b1, 1'b0);
      n++;
    end while (!(bus.oValid && bus.oT == 9'd250) && n < 400);
    chk("reached_250", bus.oT, 250);
    cycle(1'b1, 1'b1);
    if (PEND) push_sweep();
    n = 0;
    while (!saw_last && n < 400) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    chk("reached_last", saw_last, 1);
    cycle(1'b1, 1'b0);
    chk("busy_after_first_sweep", bus.oBusy, PEND);
    run_until_idle(0, 1000, "pending");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      chk("no_extra_sweep", {31'b0, bus.oValid | bus.oRdEn}, 0);
    end

    // t_min == t_max: one word, oLast set
    @(posedge CLK); #1 bus5.iTableDone = 1'b1;
    @(posedge CLK); #1 bus5.iTableDone = 1'b0;
    n5_rd = 0;
    n5_val = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus5.oRdEn) begin
        n5_rd++;
        chk("t5_rd_addr", bus5.oRdAddr, 5);
      end
      if (bus5.oValid) begin
        n5_val++;
        chk("t5_oT", bus5.oT, 5);
        chk("t5_last", bus5.oLast, 1);
        chk("t5_data", bus5.oData, mem[5]);
      end
      @(posedge CLK); #1;
    end
    chk("t5_reads", n5_rd, 1);
    chk("t5_words", n5_val, 1);
    chk("t5_busy_end", bus5.oBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
